// File: rtl/round_robin_dual_harness_pkg.sv
// Shared constants, types and the round-robin scan helper for the dual arbiter harness.
package round_robin_dual_harness_pkg;

    localparam int unsigned QUEUE_QUANTITY = 4;
    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned SEL_BITS       = 2;
    localparam logic [SEL_BITS-1:0] RESET_PTR = SEL_BITS'(0);

    // Result of one arbitration scan.
    typedef struct packed {
        logic                found;
        logic [SEL_BITS-1:0] idx;
    } pick_t;

    // First non-empty queue at or after start, scanning modulo the queue count.
    // The loop runs from the farthest offset down, so the nearest hit is written last.
    function automatic pick_t next_index(
        input logic [SEL_BITS-1:0]       start,
        input logic [QUEUE_QUANTITY-1:0] empty
    );
        pick_t               res;
        logic [SEL_BITS-1:0] cand;
        res.found = 1'b0;
        res.idx   = start;
        for (int k = QUEUE_QUANTITY - 1; k >= 0; k--) begin
            cand = start + SEL_BITS'(k);
            if (!empty[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/round_robin_selector.sv
// Four-queue round-robin read arbiter with registered grant outputs.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   enb       - arbiter enable
//   buf_empty - per-queue empty flags (1 = empty)
//   selector  - granted queue index (registered)
//   out_enb   - grant valid, pop the selected queue (registered)
module round_robin_selector
    import round_robin_dual_harness_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enb,
    input  logic [QUEUE_QUANTITY-1:0] buf_empty,
    output logic [SEL_BITS-1:0]       selector,
    output logic                      out_enb
);

    logic [SEL_BITS-1:0] ptr;
    pick_t               pick;

    // Scan from the priority pointer for the first non-empty queue.
    always_comb begin
        pick = next_index(ptr, buf_empty);
    end

    // Grant register and pointer; selector and ptr hold whenever no grant is made.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= RESET_PTR;
            selector <= SEL_BITS'(0);
            out_enb  <= 1'b0;
        end else if (!enb) begin
            out_enb <= 1'b0;
        end else if (pick.found) begin
            selector <= pick.idx;
            out_enb  <= 1'b1;
            ptr      <= pick.idx + SEL_BITS'(1);
        end else begin
            out_enb <= 1'b0;
        end
    end

endmodule

// File: rtl/round_robin_dual_harness.sv
// Two identical round-robin arbiters on shared inputs: a primary path and a shadow
// path that may be replaced by a gate-level netlist for equivalence checking.
// Ports:
//   clk, rst                     - clock and synchronous active-high reset
//   enb                          - arbiter enable
//   buf_empty                    - per-queue empty flags (1 = empty)
//   selector, out_enb            - primary grant index / grant valid
//   sint_selector, sint_out_enb  - shadow grant index / grant valid
module round_robin_dual_harness
    import round_robin_dual_harness_pkg::*;
#(
    parameter int unsigned QUEUE_QUANTITY = round_robin_dual_harness_pkg::QUEUE_QUANTITY,
    parameter int unsigned DATA_BITS      = round_robin_dual_harness_pkg::DATA_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enb,
    input  logic [QUEUE_QUANTITY-1:0] buf_empty,
    output logic [SEL_BITS-1:0]       selector,
    output logic                      out_enb,
    output logic [SEL_BITS-1:0]       sint_selector,
    output logic                      sint_out_enb
);

    // The selector ports are 2 bits wide, so only a 4-queue build is meaningful.
    if (QUEUE_QUANTITY != 4 || DATA_BITS == 0) begin : g_param_check
        $error("round_robin_dual_harness supports only QUEUE_QUANTITY=4 and DATA_BITS>0");
    end

    // Primary arbiter.
    round_robin_selector u_primary (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .buf_empty (buf_empty),
        .selector  (selector),
        .out_enb   (out_enb)
    );

    // Shadow arbiter; same RTL or a netlist swapped in at build time.
    round_robin_selector u_shadow (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .buf_empty (buf_empty),
        .selector  (sint_selector),
        .out_enb   (sint_out_enb)
    );

endmodule

// File: tb/tb_round_robin_dual_harness.sv
// Scoreboard bench for round_robin_dual_harness: a behavioural arbiter model pushes the
// expected grant for each driven cycle, and the entry is popped after the next edge.
module tb_round_robin_dual_harness;

    typedef struct {
        int sel;
        int oe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic [3:0] buf_empty;
    logic [1:0] selector;
    logic       out_enb;
    logic [1:0] sint_selector;
    logic       sint_out_enb;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    // Behavioural model state.
    int m_ptr = 0;
    int m_sel = 0;
    int m_oe  = 0;

    round_robin_dual_harness dut (
        .clk           (clk),
        .rst           (rst),
        .enb           (enb),
        .buf_empty     (buf_empty),
        .selector      (selector),
        .out_enb       (out_enb),
        .sint_selector (sint_selector),
        .sint_out_enb  (sint_out_enb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one edge with the given inputs.
    task automatic model_step(input bit r, input bit e, input logic [3:0] emp);
        bit hit;
        if (r) begin
            m_ptr = 0;
            m_sel = 0;
            m_oe  = 0;
        end else if (!e) begin
            m_oe = 0;
        end else begin
            hit = 0;
            for (int off = 0; off < 4; off++) begin
                int q;
                q = (m_ptr + off) % 4;
                if (!hit && emp[q] == 1'b0) begin
                    hit   = 1;
                    m_sel = q;
                    m_ptr = (q + 1) % 4;
                end
            end
            m_oe = hit ? 1 : 0;
        end
    endtask

    // Drive one cycle, push the expectation, then pop and compare after the edge.
    task automatic step(input bit r, input bit e, input logic [3:0] emp);
        exp_t ex;
        @(negedge clk);
        rst       = r;
        enb       = e;
        buf_empty = emp;
        model_step(r, e, emp);
        ex.sel = m_sel;
        ex.oe  = m_oe;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            ex = sb_q.pop_front();
            check("selector", 32'(selector), 32'(ex.sel));
            check("out_enb", 32'(out_enb), 32'(ex.oe));
            check("sint_selector", 32'(sint_selector), 32'(selector));
            check("sint_out_enb", 32'(sint_out_enb), 32'(out_enb));
            check("no_x", 32'($isunknown({selector, out_enb, sint_selector, sint_out_enb})), 32'd0);
        end
    endtask

    initial begin
        int seq_a[6];
        int guard;
        seq_a = '{0, 1, 2, 3, 0, 1};
        rst       = 1'b1;
        enb       = 1'b1;
        buf_empty = 4'b0000;

        // Reset held two edges with all queues full.
        step(1, 1, 4'b0000);
        step(1, 1, 4'b0000);
        check("rst_sel", 32'(selector), 32'd0);
        check("rst_oe", 32'(out_enb), 32'd0);
        check("rst_sint_oe", 32'(sint_out_enb), 32'd0);

        // Plain rotation from queue 0.
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 4'b0000);
            check("rot_seq", 32'(selector), 32'(seq_a[i]));
            check("rot_oe", 32'(out_enb), 32'd1);
        end

        // Queue 0 empty: never granted.
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 4'b0001);
            check("skip0_not0", 32'(selector == 2'd0), 32'd0);
        end
        for (int i = 0; i < 4; i++) step(0, 1, 4'b0000);

        // All empty, then only queue 2 ready.
        step(0, 1, 4'b1111);
        check("allempty_oe", 32'(out_enb), 32'd0);
        step(0, 1, 4'b1111);
        step(0, 1, 4'b1011);
        check("q2_sel", 32'(selector), 32'd2);
        check("q2_oe", 32'(out_enb), 32'd1);
        step(0, 1, 4'b0000);
        check("after_q2", 32'(selector), 32'd3);

        // Disable for three cycles, then resume.
        for (int i = 0; i < 3; i++) step(0, 0, 4'b0000);
        check("dis_oe", 32'(out_enb), 32'd0);
        check("dis_hold", 32'(selector), 32'd3);
        step(0, 1, 4'b0000);
        check("resume_sel", 32'(selector), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 4'b0000);

        // Mid-rotation reset when the grant is queue 2.
        guard = 0;
        while (!(selector == 2'd2 && out_enb) && guard < 8) begin
            step(0, 1, 4'b0000);
            guard++;
        end
        check("reach_sel2", 32'(selector == 2'd2), 32'd1);
        step(1, 1, 4'b0000);
        check("midrst_sel", 32'(selector), 32'd0);
        check("midrst_oe", 32'(out_enb), 32'd0);
        step(0, 1, 4'b0000);
        check("post_rst_sel", 32'(selector), 32'd0);
        check("post_rst_oe", 32'(out_enb), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                 4'($urandom_range(0, 15)));
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
